// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions, serializer states and the bit-period clamp.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CLKDIV = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_LEVEL_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // Divider values below 2 would make a zero/one-cycle bit; clamp them.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/uart_tx_responder_if.sv
// Native memory-bus link between the processor (master) and the UART (slave).
interface uart_tx_responder_if;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a read-enabled registered read port; dout holds the
// popped word from the cycle after pop. A push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic [LW-1:0]    level_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        level_next = level_reg + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
        if (do_pop) begin
            dout_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_next;
        end
    end

    assign dout  = dout_reg;
    assign level = level_reg;

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter: bus decode and register file, TX FIFO,
// and a divider-timed serializer driving uart_tx.
module uart_tx_responder
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_responder_if.slave   bus,
    output logic                 uart_tx
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic           hit;
    logic [1:0]     offset;
    logic           is_write;
    logic           data_push_req;
    logic           ack_next;
    logic           div_wr_en;
    logic [31:0]    status_word;
    logic [31:0]    rdata_next;
    logic           ready_reg;
    logic [31:0]    rdata_reg;
    logic [15:0]    clkdiv_reg;
    logic [15:0]    clkdiv_next;

    logic           fifo_push;
    logic           fifo_pop;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [LW-1:0]  fifo_level;

    tx_state_t      state_reg;
    tx_state_t      state_next;
    logic [15:0]    cnt_reg;
    logic [15:0]    cnt_next;
    logic [2:0]     bit_reg;
    logic [2:0]     bit_next;
    logic [7:0]     shift_reg;
    logic [7:0]     shift_next;
    logic           tx_reg;
    logic           tx_next;
    logic           load_reg;
    logic [15:0]    bit_len;
    logic           boundary;

    logic           unused_bus;
    assign unused_bus = ^{bus.mem_addr[1:0], bus.mem_wdata[31:16]};

    // A DATA write only stalls when it would push into a full FIFO that is not draining this cycle.
    always_comb begin
        hit           = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
        offset        = bus.mem_addr[3:2];
        is_write      = |bus.mem_wstrb;
        data_push_req = is_write && (offset == REG_DATA) && bus.mem_wstrb[0];
        ack_next      = hit && !ready_reg && !(data_push_req && fifo_full && !fifo_pop);
        fifo_push     = ack_next && data_push_req;
        div_wr_en     = ack_next && is_write && (offset == REG_CLKDIV);

        status_word                              = '0;
        status_word[STAT_FULL]                   = fifo_full;
        status_word[STAT_EMPTY]                  = fifo_empty;
        status_word[STAT_BUSY]                   = (state_reg != S_IDLE);
        status_word[STAT_LEVEL_LSB +: LW]        = fifo_level;

        rdata_next = '0;
        if (ack_next && !is_write) begin
            case (offset)
                REG_STATUS: rdata_next = status_word;
                REG_CLKDIV: rdata_next = {16'h0000, clkdiv_reg};
                default:    rdata_next = '0;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_div_lane
            assign clkdiv_next[gi*8 +: 8] = (div_wr_en && bus.mem_wstrb[gi])
                                          ? bus.mem_wdata[gi*8 +: 8]
                                          : clkdiv_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_reg  <= 1'b0;
            rdata_reg  <= '0;
            clkdiv_reg <= DEFAULT_DIV;
        end else begin
            ready_reg  <= ack_next;
            rdata_reg  <= rdata_next;
            clkdiv_reg <= clkdiv_next;
        end
    end

    assign bus.mem_ready = ready_reg;
    assign bus.mem_rdata = rdata_reg;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (bus.mem_wdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bit_len  = eff_div(clkdiv_reg);
    assign boundary = (cnt_reg <= 16'd1);

    // The popped byte arrives one cycle after the pop; the start bit is always
    // at least two cycles long, so it lands before the first data bit is needed.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        fifo_pop   = 1'b0;

        if (load_reg) begin
            shift_next = fifo_dout;
        end
        if (state_reg != S_IDLE) begin
            cnt_next = boundary ? bit_len : cnt_reg - 16'd1;
        end

        case (state_reg)
            S_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = S_START;
                    cnt_next   = bit_len;
                    tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (boundary) begin
                    state_next = S_DATA;
                    bit_next   = 3'd0;
                    tx_next    = shift_reg[0];
                end
            end
            S_DATA: begin
                if (boundary) begin
                    if (bit_reg == 3'd7) begin
                        state_next = S_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                    end
                end
            end
            S_STOP: begin
                if (boundary) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = S_START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 16'd2;
            bit_reg   <= 3'd0;
            shift_reg <= 8'h00;
            tx_reg    <= 1'b1;
            load_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            load_reg  <= fifo_pop;
        end
    end

    assign uart_tx = tx_reg;

endmodule

// File: tb/tb_uart_tx_responder.sv
// Scoreboard bench: bus responses and UART frames are predicted at issue time
// and checked by independent monitors against a simple behavioural model.
module tb_uart_tx_responder;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int          DDIV = 868;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_tx;

    uart_tx_responder_if bus();

    uart_tx_responder #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'(DDIV))
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          bit_time = DDIV;
    bit          in_frame = 1'b0;
    logic [31:0] rsp_q[$];
    logic [7:0]  byte_q[$];
    int          start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Bus response monitor
    always @(negedge clk) begin
        if (bus.mem_ready === 1'b1) begin
            if (rsp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: mem_ready=1 with no access outstanding, expected 0");
            end else begin
                check("rdata", bus.mem_rdata, rsp_q.pop_front());
            end
        end else if (!reset && bus.mem_rdata !== 32'h0) begin
            n_checks++;
            $display("FAIL rdata_idle: got 0x%08h while not ready, expected 0", bus.mem_rdata);
        end
    end

    // UART frame monitor: expected waveform is {stop, data LSB-first, start}, each bit bit_time samples
    initial begin
        int         bt;
        int         bad;
        bit         aborted;
        logic [7:0] eb;
        logic [7:0] got;
        logic [9:0] wave;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                bt       = bit_time;
                in_frame = 1'b1;
                start_q.push_back(cyc);
                if (byte_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, expected none", cyc);
                    eb = 8'h00;
                end else begin
                    eb = byte_q.pop_front();
                end
                wave    = {1'b1, eb, 1'b0};
                bad     = 0;
                aborted = 1'b0;
                got     = 8'h00;
                for (int s = 0; s < 10 * bt; s++) begin
                    if (s > 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (uart_tx !== wave[s / bt]) bad++;
                    if ((s % bt) == (bt / 2) && (s / bt) >= 1 && (s / bt) <= 8)
                        got[(s / bt) - 1] = uart_tx;
                end
                if (!aborted) begin
                    $display("frame: byte 0x%02h expected 0x%02h bit_time %0d bad_samples %0d", got, eb, bt, bad);
                    check("frame_wave", bad, 0);
                    check("frame_data", {24'h0, got}, {24'h0, eb});
                end else begin
                    $display("frame: aborted by reset");
                end
                in_frame = 1'b0;
            end
        end
    end

    task automatic bus_access(input string name, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input logic [31:0] exp_rd,
                              input int exp_lat, output int lat);
        bit is_hit;
        int seen;
        is_hit = (a[31:4] == BASE[31:4]);
        lat    = 0;
        seen   = 0;
        if (is_hit) rsp_q.push_back(exp_rd);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = wd;
        bus.mem_wstrb = ws;
        if (is_hit) begin
            forever begin
                @(posedge clk); #1;
                lat++;
                if (bus.mem_ready === 1'b1) break;
                if (lat >= 2000) begin
                    n_checks++;
                    $display("FAIL %s_timeout: no mem_ready within %0d cycles, expected ack", name, lat);
                    rsp_q.delete();
                    break;
                end
            end
        end else begin
            repeat (10) begin
                @(posedge clk); #1;
                lat++;
                if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) seen++;
            end
            check({name, "_noack"}, seen, 0);
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        $display("bus %s: addr=0x%08h wdata=0x%08h wstrb=%b latency=%0d", name, a, wd, ws, lat);
        if (is_hit && exp_lat > 0) check({name, "_latency"}, lat, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic wr(input string name, input logic [3:0] off, input logic [31:0] d,
                      input logic [3:0] s, input int el);
        int l;
        bus_access(name, BASE | {28'h0, off}, d, s, 32'h0, el, l);
    endtask

    task automatic rd(input string name, input logic [3:0] off, input logic [31:0] exp);
        int l;
        bus_access(name, BASE | {28'h0, off}, 32'h0, 4'h0, exp, 1, l);
    endtask

    task automatic send(input logic [7:0] b);
        byte_q.push_back(b);
        wr("data_wr", 4'h0, {$urandom_range(0, 255), 16'h0, b}, 4'b0001, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((byte_q.size() != 0 || in_frame || uart_tx !== 1'b1) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20000) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d frames still pending, expected 0", byte_q.size());
            byte_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int div;
        int nb;
        int zeros;
        logic [7:0] b;
        logic [31:0] a;

        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check("reset_tx", {31'h0, uart_tx}, 32'h1);
        rd("status_rst", 4'h4, 32'h0000_0002);
        rd("clkdiv_rst", 4'h8, DDIV);

        // Single frame at 4 cycles/bit
        wr("clkdiv_wr", 4'h8, 32'h0000_0004, 4'b0011, 1);
        bit_time = 4;
        send(8'h55);
        drain();

        // Divider clamp and byte-strobed write
        wr("clkdiv_wr", 4'h8, 32'h0000_0001, 4'b0011, 1);
        rd("clkdiv_rd", 4'h8, 32'h0000_0001);
        bit_time = 2;
        send(8'hC3);
        drain();
        wr("clkdiv_wr", 4'h8, 32'h0000_0368, 4'b0011, 1);
        wr("clkdiv_wr_lo", 4'h8, 32'h0000_1234, 4'b0001, 1);
        rd("clkdiv_rd", 4'h8, 32'h0000_0334);

        // Back-to-back burst: one byte goes straight to the serializer and eight fill
        // the FIFO, so the tenth write has to wait for the first frame to finish
        wr("clkdiv_wr", 4'h8, 32'h0000_0002, 4'b0011, 1);
        bit_time = 2;
        start_q.delete();
        for (int i = 0; i < 10; i++) begin
            byte_q.push_back(8'(i));
            bus_access("burst_wr", BASE, 32'(i), 4'b0001, 32'h0, (i == 9) ? -1 : 1, lat);
        end
        check("burst_stall", {31'h0, lat > 1}, 32'h1);
        drain();
        check("burst_frames", start_q.size(), 10);
        for (int k = 1; k < 10 && k < start_q.size(); k++)
            check("burst_gap", start_q[k] - start_q[k-1], 20);

        // STATUS while busy: first byte is in flight, two are queued
        wr("clkdiv_wr", 4'h8, 32'h0000_0014, 4'b0011, 1);
        bit_time = 20;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        rd("status_busy", 4'h4, 32'h0000_0204);
        drain();
        rd("status_idle", 4'h4, 32'h0000_0002);

        // Misses, reserved offset, ignored writes
        bus_access("miss_rd", 32'h0300_0000, 32'h0, 4'h0, 32'h0, -1, lat);
        bus_access("miss_wr", 32'h0300_0000, 32'h0000_00AA, 4'b0001, 32'h0, -1, lat);
        rd("rsvd_rd", 4'hC, 32'h0);
        wr("rsvd_wr", 4'hC, 32'hFFFF_FFFF, 4'b1111, 1);
        wr("status_wr", 4'h4, 32'hFFFF_FFFF, 4'b1111, 1);
        wr("data_nostrb0", 4'h0, 32'h0000_00EE, 4'b1110, 1);
        rd("data_rd", 4'h0, 32'h0);
        rd("status_after", 4'h4, 32'h0000_0002);

        // Randomized rounds
        for (int r = 0; r < 4; r++) begin
            div = $urandom_range(0, 5);
            wr("clkdiv_wr", 4'h8, 32'(div), 4'b0011, 1);
            rd("clkdiv_rd", 4'h8, 32'(div));
            bit_time = (div < 2) ? 2 : div;
            nb = $urandom_range(3, 12);
            for (int j = 0; j < nb; j++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: begin
                        b = 8'($urandom_range(0, 255));
                        byte_q.push_back(b);
                        bus_access("rand_data", BASE, {$urandom_range(0, 65535), 8'h00, b} | 32'h0,
                                   4'b0001 | 4'($urandom_range(0, 15)), 32'h0, -1, lat);
                    end
                    6: wr("rand_nopush", 4'h0, $urandom, 4'($urandom_range(1, 7)) << 1, 1);
                    7: rd("rand_rsvd", 4'hC, 32'h0);
                    8: begin
                        a = 32'h0400_0000 | ($urandom & 32'h00FF_FFFC);
                        bus_access("rand_miss", a, $urandom, 4'b0001, 32'h0, -1, lat);
                    end
                    default: rd("rand_data_rd", 4'h0, 32'h0);
                endcase
            end
            drain();
            rd("status_idle", 4'h4, 32'h0000_0002);
        end

        // Reset in the middle of data bit 3 of 0xA5 (bit 3 is 0)
        wr("clkdiv_wr", 4'h8, 32'h0000_0008, 4'b0011, 1);
        bit_time = 8;
        send(8'hA5);
        lat = 0;
        while (uart_tx !== 1'b0 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("start_seen", {31'h0, uart_tx}, 32'h0);
        repeat (34) @(posedge clk);
        #1;
        check("bit3_value", {31'h0, uart_tx}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_midframe_tx", {31'h0, uart_tx}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        byte_q.delete();
        rsp_q.delete();
        rd("status_rst2", 4'h4, 32'h0000_0002);
        rd("clkdiv_rst2", 4'h8, DDIV);
        zeros = 0;
        repeat (50) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) zeros++;
        end
        check("idle_after_reset", zeros, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded 1ms, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
